// File: rtl/stream_checker_pkg.sv
// stream_checker_pkg: checker FSM state type, MISR polynomial table and pointer-width helper
package stream_checker_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} sc_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Galois right-shift taps; unknown widths fall back to x^NB + x + 1 style taps
    function automatic logic [31:0] misr_poly(input int nb);
        return nb == 8  ? 32'h0000_00B8 :
               nb == 10 ? 32'h0000_0240 :
               nb == 16 ? 32'h0000_B400 :
                          (32'd1 << (nb - 1)) | 32'd1;
    endfunction

endpackage

// File: rtl/sc_fifo.sv
// sc_fifo: show-ahead expected-sample FIFO with wrap-bit pointers and synchronous clear
module sc_fifo
    import stream_checker_pkg::*;
#(
    parameter int NB    = 10,
    parameter int DEPTH = 16
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [NB-1:0] wdata_i,
    output logic [NB-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = clog2(DEPTH);

    logic [AW:0]   wr_q, rd_q;
    logic [NB-1:0] mem_q [DEPTH];

    assign empty_o = wr_q == rd_q;
    assign full_o  = wr_q[AW-1:0] == rd_q[AW-1:0] && wr_q[AW] != rd_q[AW];
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clr_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_i && !clr_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/stream_checker.sv
// stream_checker: compares a DUT output stream against a buffered golden stream.
// Optional MISR signature on SIG when STREAM_CHECKER_MISR_EN is defined.
module stream_checker
    import stream_checker_pkg::*;
#(
    parameter int NB    = 10,
    parameter int DEPTH = 16,
    parameter int NSAMP = 1024,
    parameter int CW    = 16
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          VIN,
    input  logic [NB-1:0] DIN,
    input  logic          EXP_VIN,
    input  logic [NB-1:0] EXP_DIN,
    input  logic          CLR,
    output logic          ERR,
    output logic [CW-1:0] SAMPLE_CNT,
    output logic [CW-1:0] ERR_CNT,
    output logic          OVF,
    output logic          UNF,
    output logic          DONE,
    output logic [NB-1:0] SIG
);
    if (NSAMP < 1 || longint'(NSAMP) >= (64'd1 << CW)) begin : g_bad_nsamp
        $error("stream_checker: NSAMP must lie in 1..2**CW-1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stream_checker: DEPTH must be a power of two >= 2");
    end

    sc_state_e     state_q, state_d;
    logic          acc, cmp, pop, bypass, push, fifo_push, mism, full, empty;
    logic          err_q, err_d, ovf_q, ovf_d, unf_q, unf_d;
    logic [CW-1:0] scnt_q, scnt_d, ecnt_q, ecnt_d;
    logic [NB-1:0] head;

    sc_fifo #(.NB(NB), .DEPTH(DEPTH)) u_fifo (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .clr_i   (CLR),
        .push_i  (fifo_push),
        .pop_i   (pop),
        .wdata_i (EXP_DIN),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        acc       = state_q != ST_DONE;
        cmp       = acc && VIN;
        pop       = cmp && !empty;
        bypass    = cmp && empty && EXP_VIN;
        push      = acc && EXP_VIN && !bypass;
        fifo_push = push && (!full || pop);
        // an underflowing sample has nothing to match and always counts as an error
        mism      = pop ? head != DIN : bypass ? EXP_DIN != DIN : 1'b1;
        err_d     = cmp && mism;
        scnt_d    = scnt_q + CW'(cmp);
        ecnt_d    = ecnt_q + CW'(err_d && ecnt_q != '1);
        ovf_d     = ovf_q || (push && full && !pop);
        unf_d     = unf_q || (cmp && empty && !EXP_VIN);
        state_d   = scnt_d == CW'(NSAMP) ? ST_DONE :
                    state_q == ST_IDLE && (VIN || EXP_VIN) ? ST_RUN : state_q;
        if (CLR) begin
            err_d   = 1'b0;
            scnt_d  = '0;
            ecnt_d  = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            scnt_q  <= '0;
            ecnt_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            scnt_q  <= scnt_d;
            ecnt_q  <= ecnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign ERR        = err_q;
    assign SAMPLE_CNT = scnt_q;
    assign ERR_CNT    = ecnt_q;
    assign OVF        = ovf_q;
    assign UNF        = unf_q;
    assign DONE       = state_q == ST_DONE;

`ifdef STREAM_CHECKER_MISR_EN
    localparam logic [NB-1:0] POLY = NB'(misr_poly(NB));

    logic [NB-1:0] sig_q, sig_d;

    assign sig_d = CLR ? '0 :
                   cmp ? ({1'b0, sig_q[NB-1:1]} ^ (sig_q[0] ? POLY : '0) ^ DIN) : sig_q;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) sig_q <= '0;
        else        sig_q <= sig_d;
    end

    assign SIG = sig_q;
`else
    assign SIG = '0;
`endif

endmodule

// File: tb/tb_stream_checker.sv
// tb_stream_checker: randomized scoreboard bench; a queue-based reference model predicts
// every post-edge output and a monitor compares on each clock edge and reset assertion.
module tb_stream_checker;
    localparam int NB    = 10;
    localparam int DEPTH = 16;
    localparam int NSAMP = 8;
    localparam int CW    = 16;
    localparam int MASK  = (1 << NB) - 1;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int POLY  = 'h240;

    logic          CLK = 1'b0, RST_n = 1'b1, VIN = 1'b0, EXP_VIN = 1'b0, CLR = 1'b0;
    logic [NB-1:0] DIN = '0, EXP_DIN = '0;
    logic          ERR, OVF, UNF, DONE;
    logic [CW-1:0] SAMPLE_CNT, ERR_CNT;
    logic [NB-1:0] SIG;

    stream_checker #(.NB(NB), .DEPTH(DEPTH), .NSAMP(NSAMP), .CW(CW)) dut (
        .CLK(CLK), .RST_n(RST_n), .VIN(VIN), .DIN(DIN), .EXP_VIN(EXP_VIN),
        .EXP_DIN(EXP_DIN), .CLR(CLR), .ERR(ERR), .SAMPLE_CNT(SAMPLE_CNT),
        .ERR_CNT(ERR_CNT), .OVF(OVF), .UNF(UNF), .DONE(DONE), .SIG(SIG)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit err; int scnt; int ecnt; bit ovf; bit unf; bit done; int sig;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;

    int mq[$];
    int m_scnt, m_ecnt, m_sig;
    bit m_err, m_ovf, m_unf, m_done;

    function automatic void m_clear();
        mq.delete();
        m_scnt = 0; m_ecnt = 0; m_sig = 0;
        m_err = 0; m_ovf = 0; m_unf = 0; m_done = 0;
    endfunction

    function automatic void m_step(bit vin, int din, bit ev, int ed);
        bit byp, mis;
        byp = 0;
        mis = 0;
        m_err = 0;
        if (m_done) return;
        if (vin) begin
            if (mq.size() > 0) mis = mq.pop_front() != din;
            else if (ev) begin byp = 1; mis = ed != din; end
            else begin m_unf = 1; mis = 1; end
            m_err = mis;
            m_scnt++;
            if (mis && m_ecnt < CMAX) m_ecnt++;
`ifdef STREAM_CHECKER_MISR_EN
            m_sig = ((m_sig >> 1) ^ ((m_sig & 1) != 0 ? POLY : 0) ^ din) & MASK;
`endif
            if (m_scnt == NSAMP) m_done = 1;
        end
        if (ev && !byp) begin
            if (mq.size() < DEPTH) mq.push_back(ed);
            else m_ovf = 1;
        end
    endfunction

    function automatic exp_t snap();
        return '{err: m_err, scnt: m_scnt, ecnt: m_ecnt, ovf: m_ovf, unf: m_unf, done: m_done, sig: m_sig};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    initial forever begin
        exp_t e;
        @(posedge CLK or negedge RST_n);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ERR", 32'(ERR), 32'(e.err));
            chk("SAMPLE_CNT", 32'(SAMPLE_CNT), e.scnt);
            chk("ERR_CNT", 32'(ERR_CNT), e.ecnt);
            chk("OVF", 32'(OVF), 32'(e.ovf));
            chk("UNF", 32'(UNF), 32'(e.unf));
            chk("DONE", 32'(DONE), 32'(e.done));
            chk("SIG", 32'(SIG), e.sig);
        end
    end

    // one stimulus cycle; asserting reset also queues the immediate async-clear expectation
    task automatic tick(bit rst, bit clr, bit vin, int din, bit ev, int ed);
        @(negedge CLK);
        if (rst && RST_n) begin m_clear(); sb.push_back(snap()); end
        RST_n = !rst; CLR = clr; VIN = vin; DIN = NB'(din); EXP_VIN = ev; EXP_DIN = NB'(ed);
        if (rst || clr) m_clear();
        else m_step(vin, din & MASK, ev, ed & MASK);
        sb.push_back(snap());
    endtask

    task automatic lag_run(int bad_idx);
        for (int c = 0; c < 16; c++)
            tick(0, 0, c >= 3 && c < 11, (c - 3 == bad_idx) ? 'h3FF : c - 3, c < 8, c);
    endtask

    initial begin
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 1, 5, 1, 5);
        tick(0, 0, 0, 0, 0, 0);
        lag_run(-1);
        tick(0, 1, 0, 0, 0, 0);
        lag_run(5);
        tick(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) tick(0, 0, 0, 0, 1, 100 + i);
        for (int i = 0; i < 10; i++) tick(0, 0, 1, 100 + i, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 0, 1, 7, 0, 0);
        tick(0, 0, 1, 9, 1, 9);
        tick(0, 0, 1, 4, 1, 5);
        tick(0, 0, 1, 2, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1, 3 * i);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, (i % 2) ? 3 * i : 3 * i + 1, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 1, 1, 1, 1);
        tick(0, 0, 0, 0, 0, 0);
        lag_run(-1);
        for (int ep = 0; ep < 40; ep++) begin
            int gold[64];
            int k, j, ev_w, vin_w;
            bit ev, vin;
            k = 0; j = 0;
            ev_w = $urandom_range(1, 4);
            vin_w = $urandom_range(1, 4);
            foreach (gold[i]) gold[i] = $urandom_range(0, MASK);
            tick(0, 1, 0, 0, 0, 0);
            repeat (30) begin
                ev = $urandom_range(0, ev_w) != 0;
                vin = $urandom_range(0, vin_w) != 0;
                if ($urandom_range(0, 39) == 0) begin
                    tick(0, 1, vin, 0, ev, 0);
                    k = 0; j = 0;
                end else begin
                    tick(0, 0, vin, gold[j] ^ ($urandom_range(0, 7) == 0 ? 1 : 0), ev, gold[k]);
                    if (vin) j++;
                    if (ev) k++;
                end
            end
        end
        repeat (3) tick(0, 0, 0, 0, 0, 0);
        @(posedge CLK);
        #2;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
